// File: rtl/psc_trigger_pkg.sv
// Shared definitions for the PSC trigger link: FSM state encoding and link defaults.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package psc_trigger_pkg;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // Link defaults shared with the PSC_Trigger transmitter
    localparam int         DEF_CLKS_PER_BIT = 16;
    localparam logic [7:0] DEF_TRIGGER_CODE = 8'hA5;
    localparam int         DATA_W           = 8;

endpackage

// File: rtl/psc_trigger_rx_if.sv
// Signal bundle between a PSC trigger transmitter (master) and the receiver (slave).
// Latency: n/a (wires only).
// Backpressure: none; the serial line is free-running and results are single-cycle pulses.
interface psc_trigger_rx_if;
    import psc_trigger_pkg::*;

    logic              psc_input;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              trig_pulse;
    logic              frame_err;
    logic              busy;

    // Line driver / result consumer side
    modport master (
        output psc_input,
        input  rx_data, rx_valid, trig_pulse, frame_err, busy
    );

    // Receiver side
    modport slave (
        input  psc_input,
        output rx_data, rx_valid, trig_pulse, frame_err, busy
    );

endinterface

// File: rtl/psc_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2 clk cycles from input change to o_q.
// Backpressure: none.
module psc_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture; both stages preset to the line's idle value in reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/psc_trigger_rx.sv
// Serial receiver for PSC trigger frames (start, 8 data LSB first, stop); flags trigger code.
// Latency: result pulses one clk after the stop-bit mid-sample (2 sync + 9.5 bits after line edge).
// Backpressure: none; rx_valid/trig_pulse/frame_err are single-cycle pulses, never stalled.
module psc_trigger_rx
    import psc_trigger_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,   // even, >= 4
    parameter logic [7:0] TRIGGER_CODE = DEF_TRIGGER_CODE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       psc_input,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       trig_pulse,
    output logic       frame_err,
    output logic       busy
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(CLKS_PER_BIT / 2);

    logic             w_line_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_trig;
    logic             r_ferr;

    logic             w_mid;
    logic             w_shift_en;
    logic             w_load;
    logic             w_trig_set;
    logic             w_ferr_set;

    psc_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (psc_input),
        .o_q   (w_line_s)
    );

    // The counter reads 1 in the cycle after the start edge, so hitting CNT_MID marks
    // the centre of every bit period measured from t0.
    assign w_mid = (r_cnt == CNT_MID);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (!w_line_s) w_state_nxt = ST_START;
            ST_START:     if (w_mid) w_state_nxt = w_line_s ? ST_IDLE : ST_DATA;
            ST_DATA:      if (w_mid && (r_bit_idx == 3'd7)) w_state_nxt = ST_STOP;
            ST_STOP:      if (w_mid) w_state_nxt = w_line_s ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (w_line_s) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode: sample strobes and result events
    always_comb begin
        w_shift_en = 1'b0;
        w_load     = 1'b0;
        w_ferr_set = 1'b0;
        case (r_state)
            ST_DATA: w_shift_en = w_mid;
            ST_STOP: begin
                w_load     = w_mid &&  w_line_s;
                w_ferr_set = w_mid && !w_line_s;
            end
            default: ;
        endcase
        w_trig_set = w_load && (r_shift == TRIGGER_CODE);
    end

    // Bit-timing counter and bit index; IDLE preloads 1 on the start edge so the
    // following state sees the count of cycles elapsed since t0
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt     <= w_line_s ? CNT_W'(0) : CNT_W'(1);
                    r_bit_idx <= '0;
                end
                ST_WAIT_IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                end
                default: begin
                    r_cnt <= (r_cnt == CNT_MAX) ? CNT_W'(0) : r_cnt + CNT_W'(1);
                    if (w_shift_en) r_bit_idx <= r_bit_idx + 3'd1;
                end
            endcase
        end
    end

    // Data shift register, LSB arrives first and ends up in bit 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (w_shift_en) begin
            r_shift <= {w_line_s, r_shift[7:1]};
        end
    end

    // Registered results: byte holds until the next good frame, flags are one-cycle pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_trig     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            if (w_load) r_rx_data <= r_shift;
            r_rx_valid <= w_load;
            r_trig     <= w_trig_set;
            r_ferr     <= w_ferr_set;
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign trig_pulse = r_trig;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/psc_trigger_rx.md
PSC_TRIGGER_RX -- requirements
Module: psc_trigger_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clocks per serial bit; legal values are even and at least 4.
REQ-002 The block SHALL have parameter TRIGGER_CODE, default 8'hA5, meaning the data byte that constitutes a trigger frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port psc_input, input, 1 bit: asynchronous serial line from the PSC trigger transmitter output; idles high.
REQ-006 The block SHALL have port rx_data, output, 8 bits: the last received byte.
REQ-007 The block SHALL have port rx_valid, output, 1 bit: one-clock pulse when rx_data updates.
REQ-008 The block SHALL have port trig_pulse, output, 1 bit: one-clock pulse when a valid frame equals TRIGGER_CODE.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-clock pulse when the stop bit is sampled low.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 Frame format SHALL be: start bit low, 8 data bits LSB first, one stop bit high, each CLKS_PER_BIT clocks long.
REQ-012 psc_input SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (line_s).
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 IDLE->START SHALL occur on the first cycle line_s is low; call that cycle t0.
REQ-015 In START, line_s SHALL be sampled at t0+CLKS_PER_BIT/2; if it is high, the FSM returns to IDLE with no output (glitch rejected); if it is low, the FSM goes to DATA.
REQ-016 Data bit k (k=0..7) SHALL be sampled at t0+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT and shifted into a register LSB first.
REQ-017 The stop bit SHALL be sampled at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
REQ-018 If the stop bit is high, the block SHALL in the next cycle load rx_data, pulse rx_valid, pulse trig_pulse if the byte equals TRIGGER_CODE, and enter IDLE.
REQ-019 If the stop bit is low, the block SHALL in the next cycle pulse frame_err, leave rx_data unchanged, keep rx_valid and trig_pulse low, and enter WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL return to IDLE only on the first cycle line_s is high, so a held-low (break) line yields exactly one frame_err.
REQ-021 A falling edge arriving in the same cycle as the REQ-018 IDLE transition SHALL be detected in IDLE on the following cycle; back-to-back frames SHALL be received without loss.
REQ-022 The bit-timing counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count from 0 to CLKS_PER_BIT-1 and wrap; the bit index SHALL be 3 bits.
REQ-023 rx_valid, trig_pulse and frame_err SHALL never be high for more than one consecutive cycle, and frame_err SHALL never coincide with rx_valid.

Reset
REQ-024 While reset is low at a clock edge, the block SHALL force: state IDLE, counters 0, synchronizer flops 1, rx_data 8'h00, rx_valid 0, trig_pulse 0, frame_err 0, busy 0.
REQ-025 A reset asserted mid-frame SHALL abandon the frame with no output pulse; after release, the block SHALL resynchronize on the next falling edge.

Structure
REQ-026 Package psc_trigger_pkg SHALL hold the FSM state typedef, the default TRIGGER_CODE and the default CLKS_PER_BIT, which are shared with the PSC_Trigger transmitter.
REQ-027 The synchronizer SHALL be a separate sub-module, psc_sync2 (2 flops, reset value parameterizable); everything else SHALL live in psc_trigger_rx.

Verification
REQ-028 Bench: clk period 20 ns, CLKS_PER_BIT=16; drive frame 8'hA5 -> exactly one rx_valid, rx_data=8'hA5, one trig_pulse, the pulse lands 1 cycle after the stop sample.
REQ-029 Bench: drive frame 8'h3C -> rx_valid with rx_data=8'h3C, trig_pulse stays low.
REQ-030 Bench: drive a 4-clock low glitch on an idle line -> no outputs, busy returns low by t0+9, and the next frame 8'hA5 is received correctly.
REQ-031 Bench: drive frame with stop bit low, then hold the line low 100 clocks -> exactly one frame_err, no rx_valid, busy high until the line returns high.
REQ-032 Bench: drive frames 8'hA5, 8'h00 back-to-back with no idle gap -> two rx_valid pulses with data A5 then 00, one trig_pulse.
REQ-033 Bench: assert reset low during data bit 3 of a frame -> all outputs reset values, no pulses; the next full 8'hA5 frame produces trig_pulse.
